// File: rtl/numeric_entry_fsm_if.sv
// Scan-code input and entry-status bundle for numeric_entry_fsm.
// Latency: none; this is wiring only.
// Backpressure: none; data_en is a one-cycle strobe with no ready.
interface numeric_entry_fsm_if #(
  parameter int DIGITS = 3,
  parameter int VAL_W  = 10
);
  logic [7:0]          data;
  logic                data_en;
  logic                set;
  logic [VAL_W-1:0]    value;
  logic                commit;
  logic                clamped;
  logic [4*DIGITS-1:0] live_bcd;
  logic [2:0]          count;

  // Keyboard side: drives scan codes and observes the entry state.
  modport master (
    output data, data_en,
    input  set, value, commit, clamped, live_bcd, count
  );

  // Controller side.
  modport slave (
    input  data, data_en,
    output set, value, commit, clamped, live_bcd, count
  );
endinterface

// File: rtl/numeric_entry_fsm.sv
// PS/2 numeric entry: accumulates decimal digits, edits them, commits a clamped value on Enter.
// Latency: 1 cycle from a data_en byte to the updated outputs.
// Backpressure: none; every strobed byte is consumed. KEYPAD_EN adds keypad digit codes.
module numeric_entry_fsm #(
  parameter int DIGITS    = 3,
  parameter int VAL_W     = 10,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 999,
  parameter int RESET_VAL = 1
) (
  input logic                 Clock,
  input logic                 nReset,
  numeric_entry_fsm_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam logic [VAL_W:0] MIN_W = (VAL_W+1)'(MIN_VAL);
  localparam logic [VAL_W:0] MAX_W = (VAL_W+1)'(MAX_VAL);

  typedef enum logic [0:0] {IDLE, ENTRY} state_t;

  state_t           state;
  logic             brk;
  logic             ext;
  logic [BW-1:0]    digits;
  logic [2:0]       cnt;
  logic [VAL_W-1:0] value_r;
  logic             set_r;
  logic             commit_r;
  logic             clamped_r;

  logic             key_dig;
  logic [3:0]       dig;
  logic             key_ent;
  logic             key_bs;
  logic             key_esc;
  logic [BW-1:0]    shl;
  logic [BW-1:0]    shr;
  logic [VAL_W:0]   bin_v;
  logic [VAL_W:0]   clamp_v;
  logic             clamp_hit;

  // Decode the strobed byte into a key event; bytes following a break or
  // extended prefix are swallowed here (only E0 5A survives, as Enter).
  always_comb begin
    key_dig = 1'b0;
    dig     = 4'd0;
    key_ent = 1'b0;
    key_bs  = 1'b0;
    key_esc = 1'b0;
    if (data_is_key(bus.data) && !brk) begin
      if (ext) begin
        key_ent = (bus.data == 8'h5A);
      end else begin
        case (bus.data)
          8'h45: begin key_dig = 1'b1; dig = 4'd0; end
          8'h16: begin key_dig = 1'b1; dig = 4'd1; end
          8'h1E: begin key_dig = 1'b1; dig = 4'd2; end
          8'h26: begin key_dig = 1'b1; dig = 4'd3; end
          8'h25: begin key_dig = 1'b1; dig = 4'd4; end
          8'h2E: begin key_dig = 1'b1; dig = 4'd5; end
          8'h36: begin key_dig = 1'b1; dig = 4'd6; end
          8'h3D: begin key_dig = 1'b1; dig = 4'd7; end
          8'h3E: begin key_dig = 1'b1; dig = 4'd8; end
          8'h46: begin key_dig = 1'b1; dig = 4'd9; end
`ifdef KEYPAD_EN
          8'h70: begin key_dig = 1'b1; dig = 4'd0; end
          8'h69: begin key_dig = 1'b1; dig = 4'd1; end
          8'h72: begin key_dig = 1'b1; dig = 4'd2; end
          8'h7A: begin key_dig = 1'b1; dig = 4'd3; end
          8'h6B: begin key_dig = 1'b1; dig = 4'd4; end
          8'h73: begin key_dig = 1'b1; dig = 4'd5; end
          8'h74: begin key_dig = 1'b1; dig = 4'd6; end
          8'h6C: begin key_dig = 1'b1; dig = 4'd7; end
          8'h75: begin key_dig = 1'b1; dig = 4'd8; end
          8'h7D: begin key_dig = 1'b1; dig = 4'd9; end
`endif
          8'h5A: key_ent = 1'b1;
          8'h66: key_bs  = 1'b1;
          8'h76: key_esc = 1'b1;
          default: ;
        endcase
      end
    end
  end

  function automatic logic data_is_key(input logic [7:0] b);
    return (b != 8'hF0) && (b != 8'hE0);
  endfunction

  // Buffer shifts, BCD-to-binary conversion (most significant digit first) and range clamp.
  always_comb begin
    shl       = digits << 4;
    shl[3:0]  = dig;
    shr       = digits >> 4;
    bin_v     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      bin_v = bin_v * (VAL_W+1)'(10) + (VAL_W+1)'(digits[4*i +: 4]);
    end
    clamp_v   = bin_v;
    clamp_hit = 1'b0;
    if (bin_v < MIN_W) begin
      clamp_v   = MIN_W;
      clamp_hit = 1'b1;
    end else if (bin_v > MAX_W) begin
      clamp_v   = MAX_W;
      clamp_hit = 1'b1;
    end
  end

  // Prefix tracking and the IDLE/ENTRY editor with registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      brk       <= 1'b0;
      ext       <= 1'b0;
      digits    <= '0;
      cnt       <= 3'd0;
      value_r   <= VAL_W'(RESET_VAL);
      set_r     <= 1'b1;
      commit_r  <= 1'b0;
      clamped_r <= 1'b0;
    end else begin
      commit_r  <= 1'b0;
      clamped_r <= 1'b0;
      if (bus.data_en) begin
        if (bus.data == 8'hF0) begin
          brk <= 1'b1;
        end else if (bus.data == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (key_dig) begin
              digits <= BW'(dig);
              cnt    <= 3'd1;
              set_r  <= 1'b0;
              state  <= ENTRY;
            end
          end
          ENTRY: begin
            if (key_dig) begin
              if (cnt < 3'(DIGITS)) begin
                digits <= shl;
                cnt    <= cnt + 3'd1;
              end
            end else if (key_bs) begin
              if (cnt != 3'd0) begin
                digits <= shr;
                cnt    <= cnt - 3'd1;
              end
            end else if (key_esc || (key_ent && cnt == 3'd0)) begin
              digits <= '0;
              cnt    <= 3'd0;
              set_r  <= 1'b1;
              state  <= IDLE;
            end else if (key_ent) begin
              // Digits stay in the buffer so the display keeps showing them.
              value_r   <= clamp_v[VAL_W-1:0];
              commit_r  <= 1'b1;
              clamped_r <= clamp_hit;
              set_r     <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.set      = set_r;
  assign bus.value    = value_r;
  assign bus.commit   = commit_r;
  assign bus.clamped  = clamped_r;
  assign bus.live_bcd = digits;
  assign bus.count    = cnt;

endmodule

// File: tb/tb_numeric_entry_fsm.sv
// Bench for numeric_entry_fsm: scan-code sequences, commit scoreboard, editing and reset checks.
// Latency: outputs sampled on the falling edge after each strobed byte.
// Backpressure: none; a commit with no queued expectation is reported as unexpected.
module tb_numeric_entry_fsm;

  localparam int DIGITS = 3;
  localparam int VAL_W  = 10;

  logic Clock;
  logic nReset;

  numeric_entry_fsm_if #(.DIGITS(DIGITS), .VAL_W(VAL_W)) bus ();

  numeric_entry_fsm #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .MIN_VAL(1), .MAX_VAL(500), .RESET_VAL(1)
  ) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [VAL_W-1:0] v;
    logic             c;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_commit = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    bus.data    = b;
    bus.data_en = 1'b1;
    @(negedge Clock);
    bus.data_en = 1'b0;
    bus.data    = 8'h00;
  endtask

  task automatic expect_commit(input int v, input logic c);
    exp_t e;
    e.v = VAL_W'(v);
    e.c = c;
    sb_q.push_back(e);
  endtask

  // Commit monitor: pops the scoreboard on each pulse and checks pulse width.
  always @(negedge Clock) begin
    if (nReset) begin
      if (prev_commit) chk("commit_width", {31'd0, bus.commit}, 32'd0);
      if (bus.commit) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_commit", {31'd0, bus.commit}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("commit_value", {22'd0, bus.value}, {22'd0, e.v});
          chk("commit_clamped", {31'd0, bus.clamped}, {31'd0, e.c});
          chk("commit_set", {31'd0, bus.set}, 32'd1);
        end
      end else begin
        chk("clamped_no_commit", {31'd0, bus.clamped}, 32'd0);
      end
    end
    prev_commit = bus.commit;
  end

  task automatic chk_state(input string tag, input int val, input logic st,
                           input int bcd, input int cnt);
    chk({tag, "_value"}, {22'd0, bus.value}, 32'(val));
    chk({tag, "_set"},   {31'd0, bus.set}, {31'd0, st});
    chk({tag, "_bcd"},   {20'd0, bus.live_bcd}, 32'(bcd));
    chk({tag, "_count"}, {29'd0, bus.count}, 32'(cnt));
  endtask

  initial begin
    bus.data    = 8'h00;
    bus.data_en = 1'b0;
    nReset      = 1'b0;
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    chk_state("reset", 1, 1'b1, 0, 0);
    chk("reset_commit", {31'd0, bus.commit}, 32'd0);
    chk("reset_clamped", {31'd0, bus.clamped}, 32'd0);

    // Break codes must not add digits.
    send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
    chk_state("brk_entry", 1, 1'b0, 'h012, 2);
    expect_commit(12, 1'b0);
    send(8'h5A);
    chk_state("commit12", 12, 1'b1, 'h012, 2);

    // Fourth digit is dropped once the buffer is full.
    send(8'h26); send(8'h25); send(8'h2E); send(8'h36);
    chk_state("full", 12, 1'b0, 'h345, 3);
    expect_commit(345, 1'b0);
    send(8'h5A);
    chk_state("commit345", 345, 1'b1, 'h345, 3);

    // Zero clamps up to MIN_VAL.
    send(8'h45);
    chk_state("zero", 345, 1'b0, 'h000, 1);
    expect_commit(1, 1'b1);
    send(8'h5A);
    chk("commit_min_value", {22'd0, bus.value}, 32'd1);

    // 999 clamps down to MAX_VAL; Enter arrives as the extended E0 5A.
    send(8'h46); send(8'h46); send(8'h46);
    send(8'hE0);
    chk_state("ext_pending", 1, 1'b0, 'h999, 3);
    expect_commit(500, 1'b1);
    send(8'h5A);
    chk("commit_max_value", {22'd0, bus.value}, 32'd500);

    // Backspace and Escape editing.
    send(8'h16); send(8'h1E); send(8'h66);
    chk_state("bksp", 500, 1'b0, 'h001, 1);
    send(8'h26);
    chk_state("after_bksp", 500, 1'b0, 'h013, 2);
    send(8'h76);
    chk_state("esc", 500, 1'b1, 'h000, 0);

    // Backspace to empty stays in entry; Enter on empty behaves like Esc.
    send(8'h16); send(8'h66);
    chk_state("empty_entry", 500, 1'b0, 'h000, 0);
    send(8'h66);
    chk_state("bksp_empty", 500, 1'b0, 'h000, 0);
    send(8'h5A);
    chk_state("enter_empty", 500, 1'b1, 'h000, 0);

    // Extended non-Enter code is discarded; Enter/Backspace in IDLE ignored.
    send(8'hE0); send(8'h16); send(8'h5A); send(8'h66);
    chk_state("ext_discard", 500, 1'b1, 'h000, 0);

    // Asynchronous reset mid-entry.
    send(8'h16); send(8'h1E);
    chk_state("pre_reset", 500, 1'b0, 'h012, 2);
    #2 nReset = 1'b0;
    #1;
    chk_state("async_reset", 1, 1'b1, 0, 0);
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);

    // Keypad digit codes.
    send(8'h69);
`ifdef KEYPAD_EN
    chk_state("keypad", 1, 1'b0, 'h001, 1);
    expect_commit(1, 1'b0);
`else
    chk_state("keypad_off", 1, 1'b1, 'h000, 0);
`endif
    send(8'h5A);
    chk("keypad_value", {22'd0, bus.value}, 32'd1);

    repeat (3) @(negedge Clock);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
